ram_capture_ctrl: RTL and testbench
===================================

// Module: ram_capture_ctrl
// PURPOSE
// - Record-side counterpart of the playback RAM controller: writes a sample stream into block RAM at sequential addresses.
// - Sits between the sample source (strobe + data on s_axi_clk) and the RAM write port; GPIO sets start/stop addresses, arm and loop.
// - Reports completion, busy and sample count back to GPIO.
// PARAMETERS
// - N_ADDR_BITS  20       RAM address width
// - MEM_DEPTH    1048576  RAM depth in words; last address = MEM_DEPTH-1
// - DATA_W       16       sample/RAM word width
// PORTS
// - s_axi_clk        in   1            sole clock
// - s_axi_reset      in   1            async active-low reset
// - arm              in   1            GPIO level; rising edge starts a capture
// - abort            in   1            GPIO level; rising edge returns to IDLE
// - write_addr       in   1            GPIO level; rising edge loads set_ram_addr
// - write_stop_addr  in   1            GPIO level; rising edge latches stop_addr
// - set_ram_addr     in   N_ADDR_BITS  start address
// - stop_addr        in   N_ADDR_BITS  last address written
// - loop_capture     in   1            1 = ring-buffer mode
// - capture_en       in   1            0 = pause; samples dropped, state held
// - sample_valid     in   1            one-cycle sample strobe
// - sample_data      in   DATA_W       sample word
// - trig_in          in   1            external trigger level (CAPTURE_TRIG_EN only)
// - ram_addr         out  N_ADDR_BITS  RAM write address (registered)
// - ram_din          out  DATA_W       RAM write data (registered)
// - ram_wen          out  1            RAM write enable, one cycle per sample
// - capture_done     out  1            sticky; set on completed non-loop capture
// - busy             out  1            1 in ARMED or CAPTURE
// - wrapped          out  1            sticky; ring mode wrapped at least once
// - sample_count     out  N_ADDR_BITS+1 words written since arm, saturating
// BEHAVIOUR
// - Reset: all outputs 0; start_addr=0, stop_reg=MEM_DEPTH-1, wr_ptr=0, state IDLE. Reset mid-capture drops ram_wen at once.
// - GPIO levels converted to 1-cycle pulses via registered rising-edge detect (1 cycle latency).
// - States: IDLE, ARMED, CAPTURE, DONE.
// - IDLE/DONE + arm pulse: wr_ptr<=start_addr; clear capture_done, wrapped, sample_count; -> CAPTURE (or ARMED with trigger).
// - Any state + abort pulse -> IDLE; capture_done unchanged; abort beats arm in the same cycle.
// - write_addr pulse: start_addr<=set_ram_addr, and wr_ptr<=set_ram_addr outside CAPTURE; ignored in CAPTURE. Same cycle as arm: new address is used.
// - write_stop_addr pulse: stop_reg<=stop_addr in any state; takes effect next cycle.
// - CAPTURE, sample_valid=1, capture_en=1: next cycle ram_wen=1, ram_addr=wr_ptr, ram_din=sample_data; sample_count+1 (saturates at all-ones).
// - Pointer after a write: wr_ptr==stop_reg & !loop -> DONE, capture_done=1 (one extra cycle after last wen).
//   wr_ptr==stop_reg & loop -> wr_ptr<=start_addr, wrapped=1. Else wr_ptr==MEM_DEPTH-1 -> 0. Else wr_ptr+1.
// - stop_reg < start_addr is legal: pointer passes through MEM_DEPTH-1 -> 0 to reach it.
// - Outside write cycles ram_wen=0, ram_addr tracks wr_ptr; sample_valid outside CAPTURE or with capture_en=0 is dropped.
// - busy = (state==ARMED)|(state==CAPTURE), registered.
// CONFIGURATION
// - CAPTURE_TRIG_EN defined: trig_in port present; arm -> ARMED; trig_in rising-edge pulse -> CAPTURE.
//   A sample_valid in the same cycle as that pulse is written.
// - CAPTURE_TRIG_EN undefined: trig_in absent; arm -> CAPTURE directly; ARMED unreachable.
// STRUCTURE
// - Header ram_cap_defs.vh: state encodings (2-bit localparams IDLE/ARMED/CAPTURE/DONE).
// - Sub-module: reuse pos_oneshot for each GPIO edge detect (arm, abort, write_addr, write_stop_addr, trig_in).
// - Single always block for state/pointer; separate block for registered RAM outputs.
// TESTING
// - Reset, load start=0x10 & stop=0x13, arm, 4 samples A0..A3: wen at 0x10..0x13 with A0..A3; capture_done=1; count=4.
// - Start=MEM_DEPTH-2, stop=1, no loop, 4 samples: addresses FFFFE,FFFFF,0,1; then done.
// - Loop, start=5, stop=7, 5 samples: addresses 5,6,7,5,6; wrapped=1; busy stays 1; abort -> busy=0, done=0.
// - capture_en=0 for 3 strobes mid-capture: no wen, wr_ptr and count unchanged; resumes at same address.
// - Assert reset during capture at addr 0x20: next edge all outputs 0; re-arm restarts from start=0.
// - CAPTURE_TRIG_EN: arm, 3 strobes before trig_in rise (no wen), then strobes write from start_addr.

Source files
------------

// File: rtl/ram_capture_ctrl_pkg.sv
// rtl/ram_capture_ctrl_pkg.sv - shared state encoding for the RAM capture controller
package ram_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/ram_capture_ctrl_oneshot.sv
// rtl/ram_capture_ctrl_oneshot.sv - registered rising-edge detector turning a GPIO level into a 1-cycle pulse
module pos_oneshot (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= level;
            pulse <= level & ~prev;
        end
    end

endmodule

// File: rtl/ram_capture_ctrl.sv
// rtl/ram_capture_ctrl.sv - writes a sample stream into block RAM at sequential addresses
// Optional external trigger stage enabled by defining CAPTURE_TRIG_EN.
module ram_capture_ctrl
    import ram_capture_ctrl_pkg::*;
#(
    parameter int N_ADDR_BITS = 20,
    parameter int MEM_DEPTH   = 1048576,
    parameter int DATA_W      = 16
) (
    input  logic                   s_axi_clk,
    input  logic                   s_axi_reset,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   write_addr,
    input  logic                   write_stop_addr,
    input  logic [N_ADDR_BITS-1:0] set_ram_addr,
    input  logic [N_ADDR_BITS-1:0] stop_addr,
    input  logic                   loop_capture,
    input  logic                   capture_en,
    input  logic                   sample_valid,
    input  logic [DATA_W-1:0]      sample_data,
`ifdef CAPTURE_TRIG_EN
    input  logic                   trig_in,
`endif
    output logic [N_ADDR_BITS-1:0] ram_addr,
    output logic [DATA_W-1:0]      ram_din,
    output logic                   ram_wen,
    output logic                   capture_done,
    output logic                   busy,
    output logic                   wrapped,
    output logic [N_ADDR_BITS:0]   sample_count
);

    localparam logic [N_ADDR_BITS-1:0] LAST_ADDR = N_ADDR_BITS'(MEM_DEPTH - 1);

    cap_state_t             state;
    logic [N_ADDR_BITS-1:0] start_addr;
    logic [N_ADDR_BITS-1:0] stop_reg;
    logic [N_ADDR_BITS-1:0] wr_ptr;
    logic [N_ADDR_BITS-1:0] eff_start;
    logic                   arm_p, abort_p, waddr_p, wstop_p, trig_p;
    logic                   write_now;

    pos_oneshot u_arm   (.clk(s_axi_clk), .rst_n(s_axi_reset), .level(arm),             .pulse(arm_p));
    pos_oneshot u_abort (.clk(s_axi_clk), .rst_n(s_axi_reset), .level(abort),           .pulse(abort_p));
    pos_oneshot u_waddr (.clk(s_axi_clk), .rst_n(s_axi_reset), .level(write_addr),      .pulse(waddr_p));
    pos_oneshot u_wstop (.clk(s_axi_clk), .rst_n(s_axi_reset), .level(write_stop_addr), .pulse(wstop_p));
`ifdef CAPTURE_TRIG_EN
    pos_oneshot u_trig  (.clk(s_axi_clk), .rst_n(s_axi_reset), .level(trig_in),         .pulse(trig_p));
`else
    assign trig_p = 1'b0;
`endif

    // An address load in the same cycle as arm must be the one the capture starts from.
    assign eff_start = (waddr_p && state != ST_CAPTURE) ? set_ram_addr : start_addr;

    // The trigger cycle itself may carry a sample, so ARMED+trigger counts as a write cycle.
    assign write_now = sample_valid && capture_en && !abort_p &&
                       ((state == ST_CAPTURE) || (state == ST_ARMED && trig_p));

    always_ff @(posedge s_axi_clk or negedge s_axi_reset) begin
        if (!s_axi_reset) begin
            state        <= ST_IDLE;
            start_addr   <= '0;
            stop_reg     <= LAST_ADDR;
            wr_ptr       <= '0;
            capture_done <= 1'b0;
            wrapped      <= 1'b0;
            busy         <= 1'b0;
            sample_count <= '0;
        end else begin
            busy <= (state == ST_ARMED) || (state == ST_CAPTURE);
            if (wstop_p)
                stop_reg <= stop_addr;
            if (waddr_p && state != ST_CAPTURE) begin
                start_addr <= set_ram_addr;
                wr_ptr     <= set_ram_addr;
            end
            if (abort_p) begin
                state <= ST_IDLE;
                if (state == ST_DONE)
                    capture_done <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (state == ST_DONE)
                            capture_done <= 1'b1;
                        if (arm_p) begin
                            wr_ptr       <= eff_start;
                            capture_done <= 1'b0;
                            wrapped      <= 1'b0;
                            sample_count <= '0;
`ifdef CAPTURE_TRIG_EN
                            state        <= ST_ARMED;
`else
                            state        <= ST_CAPTURE;
`endif
                        end
                    end
                    ST_ARMED:   if (trig_p) state <= ST_CAPTURE;
                    default:    ;
                endcase
            end
            if (write_now) begin
                if (sample_count != '1)
                    sample_count <= sample_count + (N_ADDR_BITS+1)'(1);
                if (wr_ptr == stop_reg && !loop_capture) begin
                    state <= ST_DONE;
                end else if (wr_ptr == stop_reg) begin
                    wr_ptr  <= start_addr;
                    wrapped <= 1'b1;
                end else if (wr_ptr == LAST_ADDR) begin
                    wr_ptr <= '0;
                end else begin
                    wr_ptr <= wr_ptr + N_ADDR_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_reset) begin
        if (!s_axi_reset) begin
            ram_wen  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_wen  <= write_now;
            ram_addr <= wr_ptr;
            if (write_now)
                ram_din <= sample_data;
        end
    end

endmodule

// File: tb/tb_ram_capture_ctrl.sv
// tb/tb_ram_capture_ctrl.sv - directed self-checking bench for ram_capture_ctrl
module tb_ram_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm, abort, write_addr, write_stop_addr;
    logic [19:0] set_ram_addr, stop_addr;
    logic        loop_capture, capture_en, sample_valid;
    logic [15:0] sample_data;
`ifdef CAPTURE_TRIG_EN
    logic        trig_in;
`endif
    logic [19:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_wen, capture_done, busy, wrapped;
    logic [20:0] sample_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [19:0] q_addr[$];
    logic [15:0] q_data[$];

    always #5 clk = ~clk;

    ram_capture_ctrl dut (
        .s_axi_clk(clk), .s_axi_reset(rst_n),
        .arm(arm), .abort(abort), .write_addr(write_addr), .write_stop_addr(write_stop_addr),
        .set_ram_addr(set_ram_addr), .stop_addr(stop_addr),
        .loop_capture(loop_capture), .capture_en(capture_en),
        .sample_valid(sample_valid), .sample_data(sample_data),
`ifdef CAPTURE_TRIG_EN
        .trig_in(trig_in),
`endif
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wen(ram_wen),
        .capture_done(capture_done), .busy(busy), .wrapped(wrapped),
        .sample_count(sample_count)
    );

    always @(negedge clk) begin
        if (rst_n && ram_wen) begin
            q_addr.push_back(ram_addr);
            q_data.push_back(ram_din);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input int idx, input logic [19:0] ea, input logic [15:0] ed);
        logic [19:0] oa;
        logic [15:0] od;
        oa = (idx < q_addr.size()) ? q_addr[idx] : 'x;
        od = (idx < q_data.size()) ? q_data[idx] : 'x;
        chk($sformatf("wr%0d_addr", idx), 32'(oa), 32'(ea));
        chk($sformatf("wr%0d_data", idx), 32'(od), 32'(ed));
    endtask

    task automatic gpio_pulse(input int which);
        case (which)
            0: arm = 1'b1;
            1: abort = 1'b1;
            2: write_addr = 1'b1;
            default: write_stop_addr = 1'b1;
        endcase
        tick(2);
        arm = 1'b0; abort = 1'b0; write_addr = 1'b0; write_stop_addr = 1'b0;
        tick(1);
    endtask

    task automatic setup(input logic [19:0] s, input logic [19:0] e);
        set_ram_addr = s;
        gpio_pulse(2);
        stop_addr = e;
        gpio_pulse(3);
    endtask

    task automatic sample(input logic [15:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick(1);
        sample_valid = 1'b0;
        tick(1);
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        arm = 0; abort = 0; write_addr = 0; write_stop_addr = 0;
        set_ram_addr = '0; stop_addr = '0; loop_capture = 0; capture_en = 1;
        sample_valid = 0; sample_data = '0;
`ifdef CAPTURE_TRIG_EN
        trig_in = 0;
`endif
        tick(2);
        chk("rst_wen", 32'(ram_wen), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_din", 32'(ram_din), 0);
        chk("rst_done", 32'(capture_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wrapped", 32'(wrapped), 0);
        chk("rst_count", 32'(sample_count), 0);
        rst_n = 1'b1;
        tick(1);

        // basic capture 0x10..0x13
        setup(20'h10, 20'h13);
        gpio_pulse(0);
`ifdef CAPTURE_TRIG_EN
        trig_in = 1; tick(2); trig_in = 0;
`endif
        for (int i = 0; i < 4; i++) sample(16'hA0 + 16'(i));
        tick(3);
        chk("t1_nwr", 32'(q_addr.size()), 4);
        for (int i = 0; i < 4; i++) chk_wr(i, 20'h10 + 20'(i), 16'hA0 + 16'(i));
        chk("t1_done", 32'(capture_done), 1);
        chk("t1_count", 32'(sample_count), 4);
        chk("t1_busy", 32'(busy), 0);

        // wrap through end of memory
        clear_q();
        setup(20'hFFFFE, 20'h1);
        gpio_pulse(0);
`ifdef CAPTURE_TRIG_EN
        trig_in = 1; tick(2); trig_in = 0;
`endif
        for (int i = 0; i < 4; i++) sample(16'hB0 + 16'(i));
        tick(3);
        chk("t2_nwr", 32'(q_addr.size()), 4);
        chk_wr(0, 20'hFFFFE, 16'hB0);
        chk_wr(1, 20'hFFFFF, 16'hB1);
        chk_wr(2, 20'h00000, 16'hB2);
        chk_wr(3, 20'h00001, 16'hB3);
        chk("t2_done", 32'(capture_done), 1);

        // ring mode
        clear_q();
        loop_capture = 1;
        setup(20'h5, 20'h7);
        gpio_pulse(0);
`ifdef CAPTURE_TRIG_EN
        trig_in = 1; tick(2); trig_in = 0;
`endif
        for (int i = 0; i < 5; i++) sample(16'hC0 + 16'(i));
        tick(2);
        chk("t3_nwr", 32'(q_addr.size()), 5);
        chk_wr(0, 20'h5, 16'hC0);
        chk_wr(1, 20'h6, 16'hC1);
        chk_wr(2, 20'h7, 16'hC2);
        chk_wr(3, 20'h5, 16'hC3);
        chk_wr(4, 20'h6, 16'hC4);
        chk("t3_wrapped", 32'(wrapped), 1);
        chk("t3_busy", 32'(busy), 1);
        chk("t3_done_pre", 32'(capture_done), 0);
        gpio_pulse(1);
        tick(2);
        chk("t3_busy_abort", 32'(busy), 0);
        chk("t3_done_abort", 32'(capture_done), 0);
        loop_capture = 0;

        // pause with capture_en low
        clear_q();
        setup(20'h40, 20'h4F);
        gpio_pulse(0);
`ifdef CAPTURE_TRIG_EN
        trig_in = 1; tick(2); trig_in = 0;
`endif
        sample(16'hD0);
        sample(16'hD1);
        capture_en = 0;
        for (int i = 0; i < 3; i++) sample(16'hEE);
        tick(1);
        chk("t4_nwr_pause", 32'(q_addr.size()), 2);
        chk("t4_count_pause", 32'(sample_count), 2);
        chk("t4_ptr_pause", 32'(ram_addr), 32'h42);
        capture_en = 1;
        sample(16'hD2);
        tick(1);
        chk_wr(2, 20'h42, 16'hD2);
        chk("t4_count", 32'(sample_count), 3);

        // reset mid-capture
        gpio_pulse(1);
        clear_q();
        setup(20'h20, 20'h30);
        gpio_pulse(0);
`ifdef CAPTURE_TRIG_EN
        trig_in = 1; tick(2); trig_in = 0;
`endif
        sample_valid = 1; sample_data = 16'hF0;
        tick(1);
        sample_valid = 0;
        chk("t5_wen_before", 32'(ram_wen), 1);
        chk("t5_addr_before", 32'(ram_addr), 32'h20);
        rst_n = 1'b0;
        #1;
        chk("t5_wen_async", 32'(ram_wen), 0);
        tick(1);
        chk("t5_addr_rst", 32'(ram_addr), 0);
        chk("t5_din_rst", 32'(ram_din), 0);
        chk("t5_busy_rst", 32'(busy), 0);
        chk("t5_count_rst", 32'(sample_count), 0);
        rst_n = 1'b1;
        tick(1);
        clear_q();
        gpio_pulse(0);
`ifdef CAPTURE_TRIG_EN
        trig_in = 1; tick(2); trig_in = 0;
`endif
        sample(16'hF1);
        tick(1);
        chk("t5_nwr", 32'(q_addr.size()), 1);
        chk_wr(0, 20'h0, 16'hF1);
        chk("t5_count", 32'(sample_count), 1);

`ifdef CAPTURE_TRIG_EN
        // trigger gating
        gpio_pulse(1);
        clear_q();
        setup(20'h80, 20'h8F);
        gpio_pulse(0);
        for (int i = 0; i < 3; i++) sample(16'h11);
        chk("t6_nwr_armed", 32'(q_addr.size()), 0);
        chk("t6_busy_armed", 32'(busy), 1);
        trig_in = 1;
        tick(1);
        sample_valid = 1; sample_data = 16'h77;
        tick(1);
        sample_valid = 0; trig_in = 0;
        tick(1);
        sample(16'h78);
        tick(1);
        chk("t6_nwr", 32'(q_addr.size()), 2);
        chk_wr(0, 20'h80, 16'h77);
        chk_wr(1, 20'h81, 16'h78);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
